// File: rtl/riscorvo_pkg.sv
// Shared types for the riscorvo memory bridge.
//   bridge_state_t : bridge FSM encoding
//   mem_req_t      : one latched memory request (address, store data, strobes, fetch flag)
//   XLEN           : machine word width
package riscorvo_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    INSTR,
    DATA
  } bridge_state_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wstrb;
    logic            instr;
  } mem_req_t;

endpackage

// File: rtl/riscorvo_mem_bridge.sv
// Merges the core's instruction and data ports onto a single picorv32-style
// memory bus. One request is latched at a time and every mem_* output is held
// constant until mem_ready_i; responses are passed straight back to the port
// that owns the transaction.
//   clock, reset                 : rising-edge clock, async active-high reset
//   valid/addr_instr_i           : fetch request;  ready/data_instr_o : fetch response
//   valid/addr_data_i, write_data_i, read_write_i, mask_data_i : load/store request
//   ready_data_o, read_data_o    : load/store response
//   mem_valid/instr/addr/wdata/wstrb_o, mem_ready_i, mem_rdata_i : memory bus
//   err_o                        : sticky flag, memory took too long to answer
module riscorvo_mem_bridge
  import riscorvo_pkg::*;
#(
  parameter int DATA_PRIORITY  = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid_instr_i,
  input  logic [XLEN-1:0] addr_instr_i,
  output logic            ready_instr_o,
  output logic [XLEN-1:0] data_instr_o,
  input  logic            valid_data_i,
  input  logic [XLEN-1:0] addr_data_i,
  input  logic [XLEN-1:0] write_data_i,
  input  logic            read_write_i,
  input  logic [3:0]      mask_data_i,
  output logic            ready_data_o,
  output logic [XLEN-1:0] read_data_o,
  output logic            mem_valid_o,
  output logic            mem_instr_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [3:0]      mem_wstrb_o,
  input  logic            mem_ready_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            err_o
);

  localparam int WAIT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(TIMEOUT_CYCLES);

  bridge_state_t     state_q, state_d;
  mem_req_t          req_q, req_d;
  logic              write_q, write_d;
  logic              last_data_q;   // 1: most recent grant went to the data port
  logic              grant_instr, grant_data;
  logic              mem_valid_q;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      write_q     <= 1'b0;
      last_data_q <= 1'b1;
      mem_valid_q <= 1'b0;
      wait_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      write_q     <= write_d;
      mem_valid_q <= (state_d != IDLE);
      wait_q      <= wait_d;
      if (grant_data || grant_instr)
        last_data_q <= grant_data;
      if (TIMEOUT_CYCLES != 0 && wait_d == TO_VAL)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    write_d     = write_q;
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Data wins outright, or on a tie when priority is fixed or instr went last.
        if (valid_data_i && (!valid_instr_i || DATA_PRIORITY != 0 || !last_data_q))
          grant_data = 1'b1;
        else if (valid_instr_i)
          grant_instr = 1'b1;

        if (grant_instr) begin
          state_d = INSTR;
          req_d   = '{addr: addr_instr_i, wdata: '0, wstrb: '0, instr: 1'b1};
          write_d = 1'b0;
        end else if (grant_data) begin
          state_d = DATA;
          req_d   = '{addr:  addr_data_i,
                      wdata: read_write_i ? write_data_i : '0,
                      wstrb: read_write_i ? mask_data_i : 4'b0000,
                      instr: 1'b0};
          write_d = read_write_i;
        end
      end
      INSTR, DATA: begin
        if (mem_ready_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (grant_instr || grant_data)
      wait_d = '0;
    else if (mem_valid_q && !mem_ready_i && wait_q != '1)
      wait_d = wait_q + 1'b1;
    else
      wait_d = wait_q;
  end

  assign mem_valid_o   = mem_valid_q;
  assign mem_instr_o   = req_q.instr;
  assign mem_addr_o    = req_q.addr;
  assign mem_wdata_o   = req_q.wdata;
  assign mem_wstrb_o   = req_q.wstrb;
  assign err_o         = err_q;

  assign ready_instr_o = (state_q == INSTR) && mem_ready_i;
  assign ready_data_o  = (state_q == DATA) && mem_ready_i;
  assign data_instr_o  = ready_instr_o ? mem_rdata_i : '0;
  assign read_data_o   = (ready_data_o && !write_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_riscorvo_mem_bridge.sv
module tb_riscorvo_mem_bridge;

  localparam int TO0 = 4;

  typedef struct {
    logic        instr;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic err_exp = 1'b0;

  logic clock = 1'b0;
  logic reset;

  // dut0: round-robin, timeout 4
  logic        valid_instr, ready_instr, valid_data, read_write, ready_data;
  logic [31:0] addr_instr, data_instr, addr_data, write_data, read_data;
  logic [3:0]  mask_data, mem_wstrb;
  logic        mem_valid, mem_instr, mem_ready, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // dut1: fixed data priority, timeout disabled
  logic        valid_instr1, ready_instr1, valid_data1, read_write1, ready_data1;
  logic [31:0] addr_instr1, data_instr1, addr_data1, write_data1, read_data1;
  logic [3:0]  mask_data1, mem_wstrb1;
  logic        mem_valid1, mem_instr1, mem_ready1, err1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

  always #5 clock = ~clock;

  riscorvo_mem_bridge #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(TO0)) dut0 (
    .clock(clock), .reset(reset),
    .valid_instr_i(valid_instr), .addr_instr_i(addr_instr),
    .ready_instr_o(ready_instr), .data_instr_o(data_instr),
    .valid_data_i(valid_data), .addr_data_i(addr_data), .write_data_i(write_data),
    .read_write_i(read_write), .mask_data_i(mask_data),
    .ready_data_o(ready_data), .read_data_o(read_data),
    .mem_valid_o(mem_valid), .mem_instr_o(mem_instr), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata), .err_o(err)
  );

  riscorvo_mem_bridge #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(0)) dut1 (
    .clock(clock), .reset(reset),
    .valid_instr_i(valid_instr1), .addr_instr_i(addr_instr1),
    .ready_instr_o(ready_instr1), .data_instr_o(data_instr1),
    .valid_data_i(valid_data1), .addr_data_i(addr_data1), .write_data_i(write_data1),
    .read_write_i(read_write1), .mask_data_i(mask_data1),
    .ready_data_o(ready_data1), .read_data_o(read_data1),
    .mem_valid_o(mem_valid1), .mem_instr_o(mem_instr1), .mem_addr_o(mem_addr1),
    .mem_wdata_o(mem_wdata1), .mem_wstrb_o(mem_wstrb1),
    .mem_ready_i(mem_ready1), .mem_rdata_i(mem_rdata1), .err_o(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] rd);
    exp_t e;
    e = '{instr: 1'b1, write: 1'b0, addr: a, wdata: 32'h0, wstrb: 4'h0, rdata: rd};
    q.push_back(e);
  endtask

  task automatic push_data(input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] m, input logic [31:0] rd);
    exp_t e;
    e = '{instr: 1'b0, write: w, addr: a, wdata: w ? wd : 32'h0,
          wstrb: w ? m : 4'h0, rdata: rd};
    q.push_back(e);
  endtask

  // Memory side of dut0: wait for a request, hold mem_ready low for 'delay'
  // cycles, then complete it and check the response against the scoreboard.
  task automatic serve(input int delay, input bit drop_early);
    exp_t e;
    int   k;
    bit   seen;
    seen = 1'b0;
    k = 0;
    while (k < 10 && !seen) begin
      @(negedge clock);
      k++;
      if (mem_valid === 1'b1) seen = 1'b1;
    end
    chk("mem_valid_rise", {31'b0, seen}, 32'd1);
    if (!seen || q.size() == 0) begin
      chk("scoreboard_nonempty", q.size(), 32'd1);
      return;
    end
    chk("grant_latency", k, 32'd1);
    e = q.pop_front();
    chk("mem_instr", mem_instr, e.instr);
    chk("mem_addr", mem_addr, e.addr);
    chk("mem_wdata", mem_wdata, e.wdata);
    chk("mem_wstrb", mem_wstrb, e.wstrb);
    chk("err_at_grant", err, err_exp);
    if (drop_early) begin
      valid_instr = 1'b0;
      valid_data  = 1'b0;
    end
    for (int i = 1; i <= delay; i++) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      @(negedge clock);
      chk("hold_valid", mem_valid, 1'b1);
      chk("hold_addr", mem_addr, e.addr);
      chk("hold_wdata", mem_wdata, e.wdata);
      chk("hold_wstrb", mem_wstrb, e.wstrb);
      chk("hold_no_ready", {ready_instr, ready_data}, 2'b00);
      if (i >= TO0) err_exp = 1'b1;
      chk("err_wait", err, err_exp);
    end
    mem_rdata = e.rdata;
    mem_ready = 1'b1;
    #1;
    chk("ready_instr", ready_instr, e.instr);
    chk("ready_data", ready_data, !e.instr);
    chk("data_instr", data_instr, e.instr ? e.rdata : 32'h0);
    chk("read_data", read_data, (!e.instr && !e.write) ? e.rdata : 32'h0);
    @(negedge clock);
    mem_ready = 1'b0;
    #1;
    chk("idle_valid_low", mem_valid, 1'b0);
    chk("idle_no_ready", {ready_instr, ready_data}, 2'b00);
    chk("idle_data_zero", data_instr | read_data, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    valid_instr = 0; addr_instr = 0; valid_data = 0; addr_data = 0;
    write_data = 0; read_write = 0; mask_data = 0; mem_ready = 0; mem_rdata = 0;
    valid_instr1 = 0; addr_instr1 = 0; valid_data1 = 0; addr_data1 = 0;
    write_data1 = 0; read_write1 = 0; mask_data1 = 0; mem_ready1 = 0; mem_rdata1 = 0;

    // reset state
    @(negedge clock);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wstrb", mem_wstrb, 4'h0);
    chk("rst_mem_instr", mem_instr, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", {ready_instr, ready_data}, 2'b00);
    reset = 1'b0;

    // fetch 0x100, memory answers 3 cycles late
    @(negedge clock);
    valid_instr = 1; addr_instr = 32'h100;
    push_fetch(32'h100, 32'h0000_0013);
    serve(3, 0);
    valid_instr = 0;

    // mem_ready while idle is ignored
    mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("idle_ready_ignored", {ready_instr, ready_data}, 2'b00);
    chk("idle_rdata_blocked", data_instr | read_data, 32'h0);
    @(negedge clock);
    mem_ready = 0;
    chk("idle_no_request", mem_valid, 1'b0);

    // store, then load
    valid_data = 1; addr_data = 32'h2000; write_data = 32'hDEAD_BEEF;
    read_write = 1; mask_data = 4'b0011;
    push_data(1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 32'h1234_5678);
    serve(2, 0);
    valid_data = 0;
    @(negedge clock);
    valid_data = 1; addr_data = 32'h2004; read_write = 0; mask_data = 4'b1111;
    push_data(0, 32'h2004, 32'h0, 4'h0, 32'hCAFE_F00D);
    serve(1, 0);
    valid_data = 0;

    // both ports held: round-robin, instr first since data went last
    @(negedge clock);
    valid_instr = 1; addr_instr = 32'h104;
    valid_data = 1; addr_data = 32'h3000; read_write = 0;
    push_fetch(32'h104, 32'hA000_0001);
    push_data(0, 32'h3000, 32'h0, 4'h0, 32'hB000_0002);
    push_fetch(32'h104, 32'hA000_0003);
    push_data(0, 32'h3000, 32'h0, 4'h0, 32'hB000_0004);
    serve(0, 0);
    serve(1, 0);
    serve(0, 0);
    serve(2, 0);
    valid_instr = 0; valid_data = 0;

    // core drops valid mid-transaction; completion still reported
    @(negedge clock);
    valid_instr = 1; addr_instr = 32'h200;
    push_fetch(32'h200, 32'h0000_0093);
    serve(2, 1);

    // timeout: memory withholds ready for 10 cycles
    @(negedge clock);
    valid_instr = 1; addr_instr = 32'h300;
    push_fetch(32'h300, 32'h1111_2222);
    serve(10, 0);
    valid_instr = 0;
    repeat (3) @(negedge clock);
    chk("err_sticky", err, 1'b1);
    valid_data = 1; addr_data = 32'h2008; read_write = 0;
    push_data(0, 32'h2008, 32'h0, 4'h0, 32'h3333_4444);
    serve(0, 0);
    valid_data = 0;

    // reset while a store is outstanding
    @(negedge clock);
    valid_data = 1; addr_data = 32'h4000; write_data = 32'h5555_AAAA;
    read_write = 1; mask_data = 4'b1100;
    @(negedge clock);
    chk("pre_rst_valid", mem_valid, 1'b1);
    chk("pre_rst_wstrb", mem_wstrb, 4'b1100);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", mem_valid, 1'b0);
    chk("async_rst_wstrb", mem_wstrb, 4'h0);
    err_exp = 1'b0;
    chk("async_rst_err", err, err_exp);
    valid_data = 0;
    @(negedge clock);
    reset = 1'b0;

    // first tie after reset goes to instr
    valid_instr = 1; addr_instr = 32'h500;
    valid_data = 1; addr_data = 32'h5000; read_write = 0;
    push_fetch(32'h500, 32'h0000_0513);
    push_data(0, 32'h5000, 32'h0, 4'h0, 32'h7777_8888);
    serve(0, 0);
    serve(1, 0);
    valid_instr = 0; valid_data = 0;
    chk("scoreboard_drained", q.size(), 32'd0);

    // fixed data priority: data wins every tie while held
    @(negedge clock);
    valid_instr1 = 1; addr_instr1 = 32'h600;
    valid_data1 = 1; addr_data1 = 32'h6000; read_write1 = 0;
    for (int unsigned n = 0; n < 4; n++) begin
      bit seen1;
      seen1 = 1'b0;
      for (int k = 0; k < 10 && !seen1; k++) begin
        @(negedge clock);
        if (mem_valid1 === 1'b1) seen1 = 1'b1;
      end
      chk("p1_valid_rise", {31'b0, seen1}, 32'd1);
      if (n == 3) begin
        chk("p1_instr_after_drop", mem_instr1, 1'b1);
        chk("p1_addr_instr", mem_addr1, 32'h600);
      end else begin
        chk("p1_data_wins", mem_instr1, 1'b0);
        chk("p1_addr_data", mem_addr1, 32'h6000);
      end
      if (n == 0) begin
        repeat (6) @(negedge clock);
        chk("p1_no_timeout", err1, 1'b0);
      end
      mem_ready1 = 1; mem_rdata1 = 32'h6600_0000 + n;
      #1;
      chk("p1_ready_data", ready_data1, n != 3);
      chk("p1_ready_instr", ready_instr1, n == 3);
      chk("p1_rdata", (n == 3) ? data_instr1 : read_data1, 32'h6600_0000 + n);
      @(negedge clock);
      mem_ready1 = 0;
      if (n == 2) valid_data1 = 0;
      if (n == 3) valid_instr1 = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
